// File: rtl/fake_diff_serializer.sv
// TMDS serializer with fake-differential outputs and a DELAYF tap-tracking controller.
// Latency: word accepted in cycle t shows its first beat on out_p in t+2 and its last beat in t+1+N.
// Backpressure: in_ready pulses once per N cycles; a missing word replays the previous one and sets underflow.
module fake_diff_serializer #(
    parameter int C_channels = 4,
    parameter int C_ddr      = 1,
    parameter int C_bits     = 10,
    parameter int C_taps     = 127
) (
    input  logic                                          clk_shift,
    input  logic                                          rst,
    input  logic [C_channels*C_bits-1:0]                  in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic                                          underflow,
    output logic [C_channels*((C_ddr != 0) ? 2 : 1)-1:0]  out_p,
    output logic [C_channels*((C_ddr != 0) ? 2 : 1)-1:0]  out_n,
    input  logic                                          dly_req,
    input  logic [7:0]                                    dly_ch,
    input  logic [6:0]                                    dly_target,
    input  logic                                          dly_rst,
    output logic                                          dly_busy,
    output logic                                          dly_done,
    output logic [6:0]                                    dly_tap,
    output logic [C_channels-1:0]                         move,
    output logic                                          loadn,
    output logic                                          dir
);

    localparam int B    = (C_ddr != 0) ? 2 : 1;
    localparam int N    = C_bits / B;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = (C_channels > 1) ? $clog2(C_channels) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);

    // ------------------------------------------------------------------
    // Serializer datapath
    // ------------------------------------------------------------------
    logic [CNTW-1:0]                     cnt_q, cnt_d;
    logic [C_channels-1:0][C_bits-1:0]   shift_q, shift_d;
    logic [C_channels-1:0][C_bits-1:0]   word_q, word_d;
    logic                                underflow_q, underflow_d;
    logic [C_channels*B-1:0]             out_p_q, out_p_d;
    logic [C_channels*B-1:0]             out_n_q, out_n_d;

    assign in_ready  = (cnt_q == CNT_LAST);
    assign underflow = underflow_q;
    assign out_p     = out_p_q;
    assign out_n     = out_n_q;

    // Beat counter and shifters: load (or replay) on the last beat, otherwise shift right by B.
    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        word_d      = word_q;
        underflow_d = underflow_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (in_valid) begin
                shift_d = in_data;
                word_d  = in_data;
            end else begin
                // Replaying the last word keeps the link toggling with a sane pattern.
                shift_d     = word_q;
                underflow_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CNTW'(1);
            for (int c = 0; c < C_channels; c++) begin
                shift_d[c] = shift_q[c] >> B;
            end
        end
    end

    // Output pins take the low B bits of each shifter; complement pin is the inverse.
    always_comb begin
        out_p_d = '0;
        for (int c = 0; c < C_channels; c++) begin
            for (int b = 0; b < B; b++) begin
                out_p_d[c*B+b] = shift_q[c][b];
            end
        end
        out_n_d = ~out_p_d;
    end

    // Serializer state registers.
    always_ff @(posedge clk_shift) begin
        if (rst) begin
            cnt_q       <= CNT_LAST;
            shift_q     <= '0;
            word_q      <= '0;
            underflow_q <= 1'b0;
            out_p_q     <= '0;
            out_n_q     <= '1;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            underflow_q <= underflow_d;
            out_p_q     <= out_p_d;
            out_n_q     <= out_n_d;
        end
    end

    // ------------------------------------------------------------------
    // DELAYF tap tracking
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZERO,
        ST_STEP,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t                           state_q, state_d;
    logic [CW-1:0]                    ch_q, ch_d;
    logic [6:0]                       target_q, target_d;
    logic                             dir_q, dir_d;
    logic                             gap_q, gap_d;
    logic [C_channels-1:0][6:0]       tap_q, tap_d;

    logic [6:0]    req_target;
    logic          req_ch_ok;
    logic [CW-1:0] req_ch;

    assign req_target = (dly_target > 7'(C_taps)) ? 7'(C_taps) : dly_target;
    assign req_ch_ok  = (dly_ch < 8'(C_channels));
    assign req_ch     = dly_ch[CW-1:0];

    assign dly_tap  = req_ch_ok ? tap_q[req_ch] : 7'd0;
    assign dly_busy = (state_q != ST_IDLE);
    // Gating with rst keeps the pins quiet and the hardware taps cleared during reset.
    assign dly_done = (state_q == ST_DONE) && !rst;
    assign move     = ((state_q == ST_STEP) && !rst) ? (C_channels'(1) << ch_q) : '0;
    assign loadn    = !(rst || (state_q == ST_ZERO));
    assign dir      = dir_q;

    // Delay FSM next-state: latch request, then alternate STEP/GAP until the tap matches.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        target_d = target_q;
        dir_d    = dir_q;
        gap_d    = gap_q;
        tap_d    = tap_q;
        case (state_q)
            ST_IDLE: begin
                if (dly_rst) begin
                    state_d = ST_ZERO;
                end else if (dly_req) begin
                    target_d = req_target;
                    if (!req_ch_ok) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_d = req_ch;
                        if (req_target == tap_q[req_ch]) begin
                            state_d = ST_DONE;
                        end else begin
                            dir_d   = (req_target < tap_q[req_ch]);
                            state_d = ST_STEP;
                        end
                    end
                end
            end
            ST_ZERO: begin
                tap_d   = '0;
                state_d = ST_DONE;
            end
            ST_STEP: begin
                tap_d[ch_q] = dir_q ? (tap_q[ch_q] - 7'd1) : (tap_q[ch_q] + 7'd1);
                gap_d       = 1'b0;
                state_d     = ST_GAP;
            end
            ST_GAP: begin
                // Two idle cycles between MOVE pulses give DELAYF time to settle.
                if (gap_q) begin
                    state_d = (tap_q[ch_q] != target_q) ? ST_STEP : ST_DONE;
                end else begin
                    gap_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Delay FSM registers; reset drops to IDLE with all taps zero to match LOADN.
    always_ff @(posedge clk_shift) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            target_q <= '0;
            dir_q    <= 1'b0;
            gap_q    <= 1'b0;
            tap_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            gap_q    <= gap_d;
            tap_q    <= tap_d;
        end
    end

endmodule

// File: tb/tb_fake_diff_serializer.sv
// Bench for fake_diff_serializer: DDR instance with tap limit 100 plus an SDR instance.
// Random and directed words checked against a per-cycle beat schedule; delay moves against a tap model.
module tb_fake_diff_serializer;

    localparam int TAPS = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [39:0] in_data;
    logic        in_valid;
    logic        dly_req;
    logic        dly_rst;
    logic [7:0]  dly_ch;
    logic [6:0]  dly_target;

    logic        in_ready_d, underflow_d;
    logic [7:0]  out_p_d, out_n_d;
    logic        dly_busy, dly_done, loadn, dir;
    logic [6:0]  dly_tap;
    logic [3:0]  move;

    logic        in_ready_s, underflow_s;
    logic [3:0]  out_p_s, out_n_s;
    logic        dly_busy_s, dly_done_s, loadn_s, dir_s;
    logic [6:0]  dly_tap_s;
    logic [3:0]  move_s;

    int checks   = 0;
    int failures = 0;
    int mtap [4];

    fake_diff_serializer #(.C_channels(4), .C_ddr(1), .C_bits(10), .C_taps(TAPS)) dut (
        .clk_shift(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_d), .underflow(underflow_d), .out_p(out_p_d), .out_n(out_n_d),
        .dly_req(dly_req), .dly_ch(dly_ch), .dly_target(dly_target), .dly_rst(dly_rst),
        .dly_busy(dly_busy), .dly_done(dly_done), .dly_tap(dly_tap), .move(move),
        .loadn(loadn), .dir(dir)
    );

    fake_diff_serializer #(.C_channels(4), .C_ddr(0), .C_bits(10), .C_taps(127)) dut_sdr (
        .clk_shift(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_s), .underflow(underflow_s), .out_p(out_p_s), .out_n(out_n_s),
        .dly_req(1'b0), .dly_ch(8'd0), .dly_target(7'd0), .dly_rst(1'b0),
        .dly_busy(dly_busy_s), .dly_done(dly_done_s), .dly_tap(dly_tap_s), .move(move_s),
        .loadn(loadn_s), .dir(dir_s)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        dly_req = 1'b0; dly_rst = 1'b0; dly_ch = 8'd0; dly_target = 7'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mtap[i] = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        dly_req = 1'b0; dly_rst = 1'b0; dly_ch = 8'd0; dly_target = 7'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (out_p_d !== 8'h00) begin failures++; $display("FAIL rst_out_p got=%h exp=00", out_p_d); end
        checks++; if (out_n_d !== 8'hFF) begin failures++; $display("FAIL rst_out_n got=%h exp=ff", out_n_d); end
        checks++; if (out_n_s !== 4'hF) begin failures++; $display("FAIL rst_out_n_sdr got=%h exp=f", out_n_s); end
        checks++; if (in_ready_d !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready_d); end
        checks++; if (underflow_d !== 1'b0) begin failures++; $display("FAIL rst_underflow got=%b exp=0", underflow_d); end
        checks++; if (dly_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", dly_busy); end
        checks++; if (dly_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", dly_done); end
        checks++; if (move !== 4'h0) begin failures++; $display("FAIL rst_move got=%h exp=0", move); end
        checks++; if (loadn !== 1'b0) begin failures++; $display("FAIL rst_loadn got=%b exp=0", loadn); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL rst_dir got=%b exp=0", dir); end
        checks++; if (dly_tap !== 7'd0) begin failures++; $display("FAIL rst_tap got=%0d exp=0", dly_tap); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mtap[i] = 0;
        #1;
        checks++; if (in_ready_d !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%b exp=1", in_ready_d); end
        checks++; if (loadn !== 1'b1) begin failures++; $display("FAIL rel_loadn got=%b exp=1", loadn); end
        checks++; if (out_p_d !== 8'h00) begin failures++; $display("FAIL rel_out_p got=%h exp=00", out_p_d); end
    endtask

    // mode 0: random words/valid, 1: ch0 = 3A5 always valid, 2: ch0 = 001 once then idle
    task automatic run_stream(input bit sdr, input int ncyc, input int vld_pct, input int mode);
        int          b, n;
        logic [7:0]  exp_p [0:299];
        logic [39:0] prev, w;
        logic [7:0]  mask, op, on;
        logic        rdy, ur, v;
        bit          uf_exp;
        b = sdr ? 1 : 2;
        n = 10 / b;
        mask = sdr ? 8'h0F : 8'hFF;
        for (int i = 0; i < 300; i++) exp_p[i] = 8'h00;
        prev = '0;
        uf_exp = 1'b0;
        do_reset();
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            op  = sdr ? {4'h0, out_p_s} : out_p_d;
            on  = sdr ? {4'h0, out_n_s} : out_n_d;
            rdy = sdr ? in_ready_s : in_ready_d;
            ur  = sdr ? underflow_s : underflow_d;
            checks++; if (op !== exp_p[k]) begin failures++; $display("FAIL stream_out_p sdr=%0d k=%0d got=%h exp=%h", sdr, k, op, exp_p[k]); end
            checks++; if (on !== (~exp_p[k] & mask)) begin failures++; $display("FAIL stream_out_n sdr=%0d k=%0d got=%h exp=%h", sdr, k, on, ~exp_p[k] & mask); end
            checks++; if (rdy !== (k % n == 0)) begin failures++; $display("FAIL stream_in_ready sdr=%0d k=%0d got=%b exp=%b", sdr, k, rdy, (k % n == 0)); end
            checks++; if (ur !== uf_exp) begin failures++; $display("FAIL stream_underflow sdr=%0d k=%0d got=%b exp=%b", sdr, k, ur, uf_exp); end
            if (mode == 2)      v = (k == 0);
            else if (mode == 1) v = 1'b1;
            else                v = ($urandom_range(99) < vld_pct);
            w[31:0]  = $urandom;
            w[39:32] = 8'($urandom);
            if (mode == 1) w[9:0] = 10'h3A5;
            if (mode == 2) w[9:0] = 10'h001;
            in_valid = v;
            in_data  = w;
            if (k % n == 0) begin
                if (!v) begin
                    w = prev;
                    uf_exp = 1'b1;
                end
                prev = w;
                for (int j = 0; j < n; j++) begin
                    if (k + 2 + j < 300) begin
                        for (int c = 0; c < 4; c++) begin
                            for (int bb = 0; bb < b; bb++) begin
                                exp_p[k+2+j][c*b+bb] = w[c*10 + j*b + bb];
                            end
                        end
                    end
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic delay_move(input int ch, input int target, input bit poke_busy);
        int   tc, k, done_at;
        bit   ok, edir;
        logic [3:0] em;
        tc = (target > TAPS) ? TAPS : target;
        ok = (ch < 4);
        k = 0;
        edir = 1'b0;
        if (ok) begin
            k = (tc > mtap[ch]) ? (tc - mtap[ch]) : (mtap[ch] - tc);
            edir = (tc < mtap[ch]);
        end
        done_at = 3 * k + 1;
        dly_ch = 8'(ch);
        #1;
        checks++; if (dly_busy !== 1'b0) begin failures++; $display("FAIL dly_idle ch=%0d got=%b exp=0", ch, dly_busy); end
        if (ok) begin
            checks++; if (dly_tap !== 7'(mtap[ch])) begin failures++; $display("FAIL dly_tap_pre ch=%0d got=%0d exp=%0d", ch, dly_tap, mtap[ch]); end
        end
        dly_req = 1'b1;
        dly_target = 7'(target);
        for (int i = 1; i <= done_at + 1; i++) begin
            @(posedge clk); #1;
            dly_req = (poke_busy && i == 2 && i < done_at);
            dly_rst = (poke_busy && i == 3 && i < done_at);
            if (dly_req) dly_target = 7'($urandom_range(127));
            em = 4'h0;
            if (ok && k > 0 && i <= 3 * k - 2 && ((i - 1) % 3 == 0)) em = 4'(1 << ch);
            checks++; if (move !== em) begin failures++; $display("FAIL dly_move ch=%0d i=%0d got=%h exp=%h", ch, i, move, em); end
            checks++; if (dly_done !== (i == done_at)) begin failures++; $display("FAIL dly_done ch=%0d i=%0d got=%b exp=%b", ch, i, dly_done, (i == done_at)); end
            checks++; if (dly_busy !== (i <= done_at)) begin failures++; $display("FAIL dly_busy ch=%0d i=%0d got=%b exp=%b", ch, i, dly_busy, (i <= done_at)); end
            checks++; if (loadn !== 1'b1) begin failures++; $display("FAIL dly_loadn ch=%0d i=%0d got=%b exp=1", ch, i, loadn); end
            if (k > 0 && i <= done_at) begin
                checks++; if (dir !== edir) begin failures++; $display("FAIL dly_dir ch=%0d i=%0d got=%b exp=%b", ch, i, dir, edir); end
            end
        end
        dly_req = 1'b0;
        dly_rst = 1'b0;
        if (ok) begin
            mtap[ch] = tc;
            #1;
            checks++; if (dly_tap !== 7'(mtap[ch])) begin failures++; $display("FAIL dly_tap_post ch=%0d got=%0d exp=%0d", ch, dly_tap, mtap[ch]); end
        end
    endtask

    task automatic test_dly_rst();
        @(posedge clk); #1;
        checks++; if (dly_busy !== 1'b0) begin failures++; $display("FAIL zr_idle got=%b exp=0", dly_busy); end
        dly_rst = 1'b1;
        dly_req = 1'b1; dly_ch = 8'd0; dly_target = 7'd50;
        @(posedge clk); #1;
        dly_rst = 1'b0; dly_req = 1'b0;
        checks++; if (loadn !== 1'b0) begin failures++; $display("FAIL zr_loadn got=%b exp=0", loadn); end
        checks++; if (dly_busy !== 1'b1) begin failures++; $display("FAIL zr_busy got=%b exp=1", dly_busy); end
        checks++; if (move !== 4'h0) begin failures++; $display("FAIL zr_move got=%h exp=0", move); end
        @(posedge clk); #1;
        checks++; if (dly_done !== 1'b1) begin failures++; $display("FAIL zr_done got=%b exp=1", dly_done); end
        checks++; if (loadn !== 1'b1) begin failures++; $display("FAIL zr_loadn_after got=%b exp=1", loadn); end
        @(posedge clk); #1;
        checks++; if (dly_busy !== 1'b0) begin failures++; $display("FAIL zr_busy_end got=%b exp=0", dly_busy); end
        for (int c = 0; c < 4; c++) begin
            mtap[c] = 0;
            dly_ch = 8'(c);
            #1;
            checks++; if (dly_tap !== 7'd0) begin failures++; $display("FAIL zr_tap ch=%0d got=%0d exp=0", c, dly_tap); end
        end
    endtask

    task automatic test_rst_mid_move();
        delay_move(1, 4, 1'b0);
        dly_ch = 8'd1; dly_target = 7'd20; dly_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            dly_req = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++; if (loadn !== 1'b0) begin failures++; $display("FAIL mid_loadn_async got=%b exp=0", loadn); end
        @(posedge clk); #1;
        checks++; if (loadn !== 1'b0) begin failures++; $display("FAIL mid_loadn got=%b exp=0", loadn); end
        checks++; if (dly_busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", dly_busy); end
        checks++; if (move !== 4'h0) begin failures++; $display("FAIL mid_move got=%h exp=0", move); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (loadn !== 1'b1) begin failures++; $display("FAIL mid_loadn_rel got=%b exp=1", loadn); end
        checks++; if (dly_busy !== 1'b0) begin failures++; $display("FAIL mid_busy_rel got=%b exp=0", dly_busy); end
        for (int c = 0; c < 4; c++) begin
            mtap[c] = 0;
            dly_ch = 8'(c);
            #1;
            checks++; if (dly_tap !== 7'd0) begin failures++; $display("FAIL mid_tap ch=%0d got=%0d exp=0", c, dly_tap); end
        end
    endtask

    task automatic test_delay_moves();
        do_reset();
        delay_move(2, 5, 1'b0);
        delay_move(2, 3, 1'b0);
        delay_move(2, 3, 1'b0);
        delay_move(0, 120, 1'b1);
        delay_move(9, 7, 1'b0);
        for (int r = 0; r < 6; r++) begin
            delay_move(int'($urandom_range(5)), int'($urandom_range(127)), 1'($urandom_range(1)));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        dly_req = 1'b0; dly_rst = 1'b0; dly_ch = 8'd0; dly_target = 7'd0;
        test_reset();
        run_stream(1'b0, 60, 100, 1);
        run_stream(1'b0, 150, 70, 0);
        run_stream(1'b1, 60, 0, 2);
        run_stream(1'b1, 120, 80, 0);
        test_delay_moves();
        test_dly_rst();
        test_rst_mid_move();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
